// File: rtl/serial_subtractor.sv
// serial_subtractor: multi-cycle unsigned subtractor computing a - b - bin over WIDTH bits,
// STEP bits per clock, with the running borrow held in a flop between slices.
//
// Parameters:
//   WIDTH - operand/result width (>= 1)
//   STEP  - bits processed per cycle (1..WIDTH, must divide WIDTH); N = WIDTH/STEP cycles per op
// Ports:
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset
//   start - request a new operation (sampled only while idle)
//   a, b  - minuend / subtrahend, captured on accepted start
//   bin   - borrow-in, captured on accepted start
//   busy  - operation in progress
//   done  - one-cycle pulse; diff/bout valid from this cycle
//   diff  - registered result, updated only on completion
//   bout  - registered final borrow-out, updated only on completion
module serial_subtractor #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned STEP  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    if (WIDTH == 0 || STEP == 0 || STEP > WIDTH || (WIDTH % STEP) != 0) begin : g_param_check
        $error("serial_subtractor: WIDTH must be >= 1 and a multiple of STEP (1 <= STEP <= WIDTH)");
    end

    localparam int unsigned N    = WIDTH / STEP;
    localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic              br_q, br_d;
    logic [WIDTH-1:0]  res_q, res_d;
    logic [WIDTH-1:0]  diff_q, diff_d;
    logic              bout_q, bout_d;
    logic              done_q, done_d;

    // STEP-bit ripple of full subtractors on the low bits of the operand shift registers.
    logic [STEP:0]     chain;
    logic [STEP-1:0]   slice;

    always_comb begin
        chain    = '0;
        slice    = '0;
        chain[0] = br_q;
        for (int i = 0; i < int'(STEP); i++) begin
            slice[i]     = a_q[i] ^ b_q[i] ^ chain[i];
            chain[i+1]   = (~a_q[i] & b_q[i]) | (~(a_q[i] ^ b_q[i]) & chain[i]);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        br_d    = br_q;
        res_d   = res_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        done_d  = 1'b0;

        case (state_q)
            StIdle: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    br_d    = bin;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                // Slices arrive LSB-first, so each one enters at the top and earlier ones move down.
                res_d = (res_q >> STEP) | (WIDTH'(slice) << (WIDTH - STEP));
                a_d   = a_q >> STEP;
                b_d   = b_q >> STEP;
                br_d  = chain[STEP];
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == CntW'(N - 1)) begin
                    diff_d  = res_d;
                    bout_d  = chain[STEP];
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            br_q    <= 1'b0;
            res_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            br_q    <= br_d;
            res_q   <= res_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q == StRun);
    assign done = done_q;
    assign diff = diff_q;
    assign bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

    logic clk;
    logic rst_n;

    // 8-bit, one bit per cycle
    logic       s81, bin81, busy81, done81, bout81;
    logic [7:0] a81, b81, diff81;
    // 8-bit, four bits per cycle
    logic       s84, bin84, busy84, done84, bout84;
    logic [7:0] a84, b84, diff84;
    // 3-bit instances share stimulus
    logic       s3, bin3, busy31, done31, bout31, busy33, done33, bout33;
    logic [2:0] a3, b3, diff31, diff33;

    int total = 0;
    int bad   = 0;
    int ndone81 = 0;
    int ndone84 = 0;
    logic [8:0] q81[$];
    logic [8:0] q84[$];
    logic [8:0] q31[$];
    logic [8:0] q33[$];
    logic [8:0] last81 = '0;

    serial_subtractor #(.WIDTH(8), .STEP(1)) u81 (
        .clk(clk), .rst_n(rst_n), .start(s81), .a(a81), .b(b81), .bin(bin81),
        .busy(busy81), .done(done81), .diff(diff81), .bout(bout81)
    );
    serial_subtractor #(.WIDTH(8), .STEP(4)) u84 (
        .clk(clk), .rst_n(rst_n), .start(s84), .a(a84), .b(b84), .bin(bin84),
        .busy(busy84), .done(done84), .diff(diff84), .bout(bout84)
    );
    serial_subtractor #(.WIDTH(3), .STEP(1)) u31 (
        .clk(clk), .rst_n(rst_n), .start(s3), .a(a3), .b(b3), .bin(bin3),
        .busy(busy31), .done(done31), .diff(diff31), .bout(bout31)
    );
    serial_subtractor #(.WIDTH(3), .STEP(3)) u33 (
        .clk(clk), .rst_n(rst_n), .start(s3), .a(a3), .b(b3), .bin(bin3),
        .busy(busy33), .done(done33), .diff(diff33), .bout(bout33)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic stray_done(input string name);
        total++;
        bad++;
        $display("FAIL %s: got done with empty scoreboard, want no done", name);
    endtask

    // Scoreboard monitors: pop the expected {bout, diff} whenever done is seen.
    always @(negedge clk) if (done81) begin
        ndone81++;
        if (q81.size() == 0) stray_done("u81 done");
        else check("u81 result", int'({bout81, diff81}), int'(q81.pop_front()));
    end
    always @(negedge clk) if (done84) begin
        ndone84++;
        if (q84.size() == 0) stray_done("u84 done");
        else check("u84 result", int'({bout84, diff84}), int'(q84.pop_front()));
    end
    always @(negedge clk) if (done31) begin
        if (q31.size() == 0) stray_done("u31 done");
        else check("u31 result", int'({5'd0, bout31, diff31}), int'(q31.pop_front()));
    end
    always @(negedge clk) if (done33) begin
        if (q33.size() == 0) stray_done("u33 done");
        else check("u33 result", int'({5'd0, bout33, diff33}), int'(q33.pop_front()));
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    // One 8-bit STEP=1 operation with latency/busy checks; optionally churns inputs during RUN.
    task automatic run81(input logic [7:0] av, input logic [7:0] bv, input logic biv,
                         input logic [7:0] ed, input logic eb, input bit toggle);
        int cyc;
        int nbusy;
        int d0;
        @(negedge clk);
        a81 = av; b81 = bv; bin81 = biv; s81 = 1'b1;
        q81.push_back({eb, ed});
        d0 = ndone81;
        @(negedge clk);
        s81 = 1'b0;
        check("u81 busy after accept", int'(busy81), 1);
        check("u81 result held during run", int'({bout81, diff81}), int'(last81));
        cyc = 1;
        nbusy = 1;
        while (!done81 && cyc < 40) begin
            if (toggle && cyc < 6) begin
                s81 = 1'($urandom); a81 = 8'($urandom); b81 = 8'($urandom); bin81 = 1'($urandom);
            end else begin
                s81 = 1'b0;
            end
            @(negedge clk);
            cyc++;
            if (busy81) nbusy++;
        end
        check("u81 latency", cyc - 1, 8);
        check("u81 busy cycles", nbusy, 8);
        check("u81 busy low at done", int'(busy81), 0);
        last81 = {eb, ed};
        repeat (3) @(negedge clk);
        check("u81 done count", ndone81 - d0, 1);
        check("u81 result held idle", int'({bout81, diff81}), int'(last81));
    endtask

    initial begin
        int c;
        int c1;
        int c2;
        int c31;
        int c33;
        int d0;
        int r;
        rst_n = 1'b0;
        s81 = 0; a81 = 0; b81 = 0; bin81 = 0;
        s84 = 0; a84 = 0; b84 = 0; bin84 = 0;
        s3 = 0; a3 = 0; b3 = 0; bin3 = 0;
        repeat (2) @(negedge clk);
        check("reset busy81", int'(busy81), 0);
        check("reset done81", int'(done81), 0);
        check("reset diff81", int'(diff81), 0);
        check("reset bout81", int'(bout81), 0);
        check("reset busy84", int'(busy84), 0);
        check("reset busy31", int'(busy31), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed 8-bit STEP=1 vectors
        run81(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
        run81(8'hA5, 8'h5A, 1'b1, 8'h4A, 1'b0, 1'b0);
        run81(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
        run81(8'h33, 8'h11, 1'b0, 8'h22, 1'b0, 1'b1);

        // STEP=4: two-edge latency, then back-to-back start held through the done cycle
        @(negedge clk);
        a84 = 8'h10; b84 = 8'h01; bin84 = 1'b0; s84 = 1'b1;
        q84.push_back({1'b0, 8'h0F});
        q84.push_back({1'b1, 8'hFB});
        d0 = ndone84;
        @(negedge clk);
        a84 = 8'h03; b84 = 8'h07; bin84 = 1'b1;
        c = 1; c1 = 0; c2 = 0;
        while (c2 == 0 && c < 30) begin
            if (c1 != 0 && c > c1) s84 = 1'b0;
            @(negedge clk);
            c++;
            if (done84) begin
                if (c1 == 0) c1 = c;
                else c2 = c;
            end
        end
        check("u84 first done latency", c1 - 1, 2);
        check("u84 back-to-back spacing", c2 - c1, 3);
        repeat (4) @(negedge clk);
        check("u84 done count", ndone84 - d0, 2);

        // Reset two cycles into RUN: everything clears, nothing completes afterwards
        @(negedge clk);
        a81 = 8'h80; b81 = 8'h01; bin81 = 1'b0; s81 = 1'b1;
        @(negedge clk);
        s81 = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort busy81", int'(busy81), 0);
        check("abort done81", int'(done81), 0);
        check("abort diff81", int'(diff81), 0);
        check("abort bout81", int'(bout81), 0);
        last81 = '0;
        @(negedge clk);
        rst_n = 1'b1;
        d0 = ndone81;
        repeat (12) @(negedge clk);
        check("no done after abort", ndone81 - d0, 0);
        check("busy81 idle after abort", int'(busy81), 0);

        // Exhaustive 3-bit sweep on STEP=1 and STEP=3
        $monitor("sweep a=%0d b=%0d bin=%0b | s1 diff=%0d bout=%0b | s3 diff=%0d bout=%0b",
                 a3, b3, bin3, diff31, bout31, diff33, bout33);
        for (int av = 0; av < 8; av++) begin
            for (int bv = 0; bv < 8; bv++) begin
                for (int biv = 0; biv < 2; biv++) begin
                    @(negedge clk);
                    a3 = 3'(av); b3 = 3'(bv); bin3 = 1'(biv); s3 = 1'b1;
                    r = av - bv - biv;
                    q31.push_back({5'd0, (r < 0), 3'(r)});
                    q33.push_back({5'd0, (r < 0), 3'(r)});
                    @(negedge clk);
                    s3 = 1'b0;
                    c = 1; c31 = 0; c33 = 0;
                    while (c31 == 0 && c < 20) begin
                        @(negedge clk);
                        c++;
                        if (done33) c33 = c;
                        if (done31) c31 = c;
                    end
                    check("u31 latency", c31 - 1, 3);
                    check("u33 latency", c33 - 1, 1);
                end
            end
        end
        $monitoroff;

        repeat (3) @(negedge clk);
        check("q81 drained", q81.size(), 0);
        check("q84 drained", q84.size(), 0);
        check("q31 drained", q31.size(), 0);
        check("q33 drained", q33.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
